// File: rtl/pulse_capture_sequencer.sv
// Per-pulse sequencer for the metadata packer: edge detection, azimuth/tick counters,
// metadata snapshot on trigger acceptance, then delay and capture gating by sample strobe.
module pulse_capture_sequencer #(
    parameter int unsigned meta_data_width = 128,
    parameter int unsigned count_width     = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       trig_in,
    input  logic                       arp_in,
    input  logic                       acp_in,
    input  logic                       strobe_in,
    input  logic [count_width-1:0]     delay_samples,
    input  logic [count_width-1:0]     n_samples,
    output logic [meta_data_width-1:0] meta_data,
    output logic                       pack_init,
    output logic                       pack_enable,
    output logic                       busy,
    output logic [count_width-1:0]     missed_trigs
);
    typedef enum logic [1:0] {IDLE, LOAD, DELAY, CAPTURE} state_t;

    state_t state, state_next;

    logic                   trig_prev, arp_prev, acp_prev;
    logic                   trig_rise, arp_rise, acp_rise, accept;
    logic [31:0]            tick_count, arp_count, trig_count;
    logic [15:0]            acp_count;
    logic [count_width-1:0] delay_latched, n_latched;
    logic [count_width-1:0] step_count, step_count_next, step_inc;

    assign trig_rise = trig_in & ~trig_prev;
    assign arp_rise  = arp_in & ~arp_prev;
    assign acp_rise  = acp_in & ~acp_prev;
    assign accept    = enable && (state == IDLE) && trig_rise;
    assign step_inc  = step_count + 1'b1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next      = state;
        step_count_next = step_count;
        if (!enable) begin
            state_next      = IDLE;
            step_count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    step_count_next = '0;
                    if (trig_rise) state_next = LOAD;
                end
                LOAD: begin
                    step_count_next = '0;
                    if (delay_latched != '0)  state_next = DELAY;
                    else if (n_latched != '0) state_next = CAPTURE;
                    else                      state_next = IDLE;
                end
                DELAY: begin
                    if (strobe_in) begin
                        if (step_inc == delay_latched) begin
                            step_count_next = '0;
                            state_next      = (n_latched != '0) ? CAPTURE : IDLE;
                        end else begin
                            step_count_next = step_inc;
                        end
                    end
                end
                CAPTURE: begin
                    if (strobe_in) begin
                        if (step_inc == n_latched) begin
                            step_count_next = '0;
                            state_next      = IDLE;
                        end else begin
                            step_count_next = step_inc;
                        end
                    end
                end
                default: begin
                    state_next      = IDLE;
                    step_count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            step_count    <= '0;
            trig_prev     <= 1'b0;
            arp_prev      <= 1'b0;
            acp_prev      <= 1'b0;
            tick_count    <= '0;
            arp_count     <= '0;
            acp_count     <= '0;
            trig_count    <= '0;
            delay_latched <= '0;
            n_latched     <= '0;
            meta_data     <= '0;
            pack_init     <= 1'b0;
            pack_enable   <= 1'b0;
            missed_trigs  <= '0;
        end else begin
            state       <= state_next;
            step_count  <= step_count_next;
            pack_init   <= accept;
            // Registered from the next state so the gate spans the whole CAPTURE state
            pack_enable <= (state_next == CAPTURE);
            if (enable) begin
                trig_prev  <= trig_in;
                arp_prev   <= arp_in;
                acp_prev   <= acp_in;
                tick_count <= tick_count + 32'd1;
                if (arp_rise) begin
                    arp_count <= arp_count + 32'd1;
                    acp_count <= '0;
                end else if (acp_rise) begin
                    acp_count <= acp_count + 16'd1;
                end
                if (accept) begin
                    trig_count    <= trig_count + 32'd1;
                    delay_latched <= delay_samples;
                    n_latched     <= n_samples;
                    meta_data     <= {n_samples, acp_count, arp_count, tick_count, trig_count + 32'd1};
                end else if (trig_rise && busy && (missed_trigs != '1)) begin
                    missed_trigs <= missed_trigs + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_capture_sequencer.sv
// Directed bench for pulse_capture_sequencer: hand-computed pulse timing, metadata
// fields, missed-trigger counting, azimuth counters, tick wrap and abort paths.
module tb_pulse_capture_sequencer;
    logic         clock = 1'b0;
    logic         reset, enable, trig_in, arp_in, acp_in, strobe_in;
    logic [15:0]  delay_samples, n_samples;
    logic [127:0] meta_data;
    logic         pack_init, pack_enable, busy;
    logic [15:0]  missed_trigs;

    int checks = 0;
    int errors = 0;

    int           init_cycles, first_init_at, first_en_at, delay_strobes, gated, busy_cycles;
    logic [127:0] meta_snap;

    always #5 clock = ~clock;

    pulse_capture_sequencer #(
        .meta_data_width(128),
        .count_width    (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .trig_in      (trig_in),
        .arp_in       (arp_in),
        .acp_in       (acp_in),
        .strobe_in    (strobe_in),
        .delay_samples(delay_samples),
        .n_samples    (n_samples),
        .meta_data    (meta_data),
        .pack_init    (pack_init),
        .pack_enable  (pack_enable),
        .busy         (busy),
        .missed_trigs (missed_trigs)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        trig_in   = 1'b0;
        arp_in    = 1'b0;
        acp_in    = 1'b0;
        strobe_in = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    // Raises trig_in for one cycle, then runs the given number of cycles with a periodic
    // strobe; extra trigger rises are issued at cycles rt_a/rt_b/rt_c.
    task automatic run_pulse(input int cycles, input int period, input int rt_a, input int rt_b, input int rt_c);
        init_cycles   = 0;
        first_init_at = -1;
        first_en_at   = -1;
        delay_strobes = 0;
        gated         = 0;
        busy_cycles   = 0;
        trig_in       = 1'b1;
        strobe_in     = 1'b0;
        for (int i = 1; i <= cycles; i++) begin
            cycle();
            if (pack_init) begin
                init_cycles++;
                if (first_init_at < 0) first_init_at = i;
                meta_snap = meta_data;
            end
            if (pack_enable && first_en_at < 0) first_en_at = i;
            if (busy) busy_cycles++;
            trig_in   = (i == rt_a) || (i == rt_b) || (i == rt_c);
            strobe_in = (period > 0) && (i % period == 0);
            if (strobe_in && pack_enable) gated++;
            if (strobe_in && busy && !pack_init && !pack_enable) delay_strobes++;
        end
        trig_in   = 1'b0;
        strobe_in = 1'b0;
    endtask

    initial begin
        delay_samples = '0;
        n_samples     = '0;
        do_reset();
        check("rst_meta", meta_data, 128'd0);
        check("rst_init", pack_init, 1'b0);
        check("rst_en", pack_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_missed", missed_trigs, 16'd0);

        // Basic pulse: delay 3, n 5, strobe every 2nd clock
        enable        = 1'b1;
        delay_samples = 16'd3;
        n_samples     = 16'd5;
        run_pulse(30, 2, -1, -1, -1);
        check("basic_init_cnt", init_cycles, 1);
        check("basic_init_at", first_init_at, 1);
        check("basic_meta", meta_snap, {16'd5, 16'd0, 32'd0, 32'd0, 32'd1});
        check("basic_delay_str", delay_strobes, 3);
        check("basic_en_at", first_en_at, 7);
        check("basic_gated", gated, 5);
        check("basic_busy_cyc", busy_cycles, 16);
        check("basic_busy_end", busy, 1'b0);

        // Zero delay: CAPTURE directly after LOAD
        delay_samples = 16'd0;
        n_samples     = 16'd4;
        run_pulse(20, 2, -1, -1, -1);
        check("zd_trig", meta_snap[31:0], 32'd2);
        check("zd_en_at", first_en_at, 2);
        check("zd_delay_str", delay_strobes, 0);
        check("zd_gated", gated, 4);

        // n = 0: init only, never enabled
        n_samples = 16'd0;
        run_pulse(10, 2, -1, -1, -1);
        check("n0_init_cnt", init_cycles, 1);
        check("n0_trig", meta_snap[31:0], 32'd3);
        check("n0_n", meta_snap[127:112], 16'd0);
        check("n0_gated", gated, 0);
        check("n0_en_seen", first_en_at, -1);
        check("n0_busy_cyc", busy_cycles, 1);

        // Missed triggers, including one on the CAPTURE->IDLE edge
        n_samples = 16'd100;
        run_pulse(110, 1, 20, 40, 101);
        check("miss_init_cnt", init_cycles, 1);
        check("miss_trig", meta_snap[31:0], 32'd4);
        check("miss_gated", gated, 100);
        check("miss_count", missed_trigs, 16'd3);
        check("miss_busy_end", busy, 1'b0);
        n_samples = 16'd0;
        run_pulse(5, 0, -1, -1, -1);
        check("miss_next_trig", meta_snap[31:0], 32'd5);
        check("miss_hold", missed_trigs, 16'd3);

        // Azimuth counters
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            acp_in = 1'b1; cycle();
            acp_in = 1'b0; cycle();
        end
        run_pulse(4, 0, -1, -1, -1);
        check("az_acp7", meta_snap[111:96], 16'd7);
        check("az_arp0", meta_snap[95:64], 32'd0);
        arp_in = 1'b1; acp_in = 1'b1; cycle();
        arp_in = 1'b0; acp_in = 1'b0; cycle();
        for (int k = 0; k < 2; k++) begin
            acp_in = 1'b1; cycle();
            acp_in = 1'b0; cycle();
        end
        run_pulse(4, 0, -1, -1, -1);
        check("az_acp2", meta_snap[111:96], 16'd2);
        check("az_arp1", meta_snap[95:64], 32'd1);
        check("az_trig", meta_snap[31:0], 32'd2);

        // Tick wrap: FFFFFFFE -> FFFFFFFF -> 00000000 at the acceptance edge
        cycle();
        force dut.tick_count = 32'hFFFF_FFFE;
        #1;
        release dut.tick_count;
        cycle();
        cycle();
        run_pulse(4, 0, -1, -1, -1);
        check("tick_wrap", meta_snap[63:32], 32'd0);

        // Abort by enable drop mid-CAPTURE
        do_reset();
        enable        = 1'b1;
        delay_samples = 16'd0;
        n_samples     = 16'd100;
        trig_in       = 1'b1;
        strobe_in     = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            trig_in = 1'b0;
        end
        check("abort_en_before", pack_enable, 1'b1);
        enable = 1'b0;
        cycle();
        check("abort_en_after", pack_enable, 1'b0);
        check("abort_busy", busy, 1'b0);
        strobe_in = 1'b0;
        trig_in   = 1'b1; cycle();
        trig_in   = 1'b0; cycle();
        cycle();
        check("abort_dis_busy", busy, 1'b0);
        check("abort_dis_init", pack_init, 1'b0);
        check("abort_dis_miss", missed_trigs, 16'd0);
        check("abort_meta_hold", meta_data[31:0], 32'd1);
        enable        = 1'b1;
        delay_samples = 16'd1;
        n_samples     = 16'd2;
        run_pulse(10, 1, -1, -1, -1);
        check("reen_trig", meta_snap[31:0], 32'd2);
        check("reen_tick_hold", meta_snap[63:32], 32'd10);
        check("reen_gated", gated, 2);

        // Reset mid-DELAY
        do_reset();
        enable        = 1'b1;
        delay_samples = 16'd50;
        n_samples     = 16'd5;
        trig_in       = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            trig_in   = (i == 3);
            strobe_in = (i % 2 == 0);
        end
        check("rstmid_busy", busy, 1'b1);
        check("rstmid_en", pack_enable, 1'b0);
        check("rstmid_missed", missed_trigs, 16'd1);
        reset = 1'b1;
        cycle();
        check("rstmid_busy_after", busy, 1'b0);
        check("rstmid_en_after", pack_enable, 1'b0);
        check("rstmid_init_after", pack_init, 1'b0);
        check("rstmid_miss_after", missed_trigs, 16'd0);
        check("rstmid_meta_after", meta_data, 128'd0);
        reset     = 1'b0;
        strobe_in = 1'b0;
        trig_in   = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
